// File: rtl/pin_entry_buffer_pkg.sv
// Shared key codes, display codes, FSM state and packet types for the PIN entry buffer.
package pin_entry_buffer_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;
  localparam logic [3:0] KEY_BKSP  = 4'hB;

  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_DASH  = 4'hB;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ENTRY = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    KC_NONE  = 3'd0,
    KC_DIGIT = 3'd1,
    KC_ENTER = 3'd2,
    KC_CLEAR = 3'd3,
    KC_BKSP  = 3'd4
  } key_class_t;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pinPac_t;

  typedef struct packed {
    logic [3:0] bcd5;
    logic [3:0] bcd4;
    logic [3:0] bcd3;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
  } bcdPac_t;

  // 0xA, 0xC and 0xD fall into KC_NONE and never affect the buffer.
  function automatic key_class_t classify(input logic [3:0] k);
    key_class_t kc;
    kc = KC_NONE;
    if (k <= 4'd9)          kc = KC_DIGIT;
    else if (k == KEY_ENTER) kc = KC_ENTER;
    else if (k == KEY_CLEAR) kc = KC_CLEAR;
    else if (k == KEY_BKSP)  kc = KC_BKSP;
    return kc;
  endfunction

endpackage

// File: rtl/pin_entry_buffer_if.sv
// Keypad decoder to PIN entry buffer link.
// tecla_valid is a single-cycle strobe qualifying tecla_value; there is no ready,
// the buffer accepts or ignores every strobe in the cycle it is presented.
interface pin_entry_buffer_if;
  logic [3:0] tecla_value;
  logic       tecla_valid;

  modport master (output tecla_value, output tecla_valid);
  modport slave  (input  tecla_value, input  tecla_valid);
endinterface

// File: rtl/entry_timeout_counter.sv
// Inactivity counter: 0-based, cleared on demand, expire asserted while running at TIMEOUT_TICKS-1.
module entry_timeout_counter #(
  parameter int TIMEOUT_TICKS = 5000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);
  localparam int CW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

  logic [CW-1:0] count;

  assign expire = run && (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        count <= '0;
    else if (clear || !run || expire) count <= '0;
    else                              count <= count + 1'b1;
  end
endmodule

// File: rtl/pin_entry_buffer.sv
// 4-digit PIN entry buffer with backspace/clear/submit/timeout and 7-segment display image.
// Build option PIN_MASK_EN: display every stored digit but the last as a dash.
module pin_entry_buffer
  import pin_entry_buffer_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 5000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  pin_entry_buffer_if.slave    key,
  output pinPac_t              pin_out,
  output logic                 pin_valid,
  output logic                 pin_error,
  output logic                 pin_timeout,
  output bcdPac_t              bcd_packet,
  output logic                 bcd_enable,
  output state_t               state_dbg
);

  state_t     state, state_n;
  logic [2:0] count, count_n;
  logic [3:0] digits   [4];
  logic [3:0] digits_n [4];
  pinPac_t    pin_n;
  logic       valid_n, error_n, timeout_n;
  logic       key_accepted;
  logic       expire;
  key_class_t kc;
  logic [1:0] bk_idx;
  logic [3:0] pos [4];
  bcdPac_t    disp_n;

  assign state_dbg = state;
  assign bk_idx    = count[1:0] - 2'd1;

  entry_timeout_counter #(.TIMEOUT_TICKS(TIMEOUT_TICKS)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (key_accepted || !enable),
    .run    (state != ST_EMPTY),
    .expire (expire)
  );

  always_comb begin
    state_n      = state;
    count_n      = count;
    digits_n     = digits;
    pin_n        = pin_out;
    valid_n      = 1'b0;
    error_n      = 1'b0;
    timeout_n    = 1'b0;
    key_accepted = 1'b0;
    kc           = key.tecla_valid ? classify(key.tecla_value) : KC_NONE;

    if (!enable) begin
      state_n  = ST_EMPTY;
      count_n  = '0;
      digits_n = '{default: '0};
      pin_n    = '0;
    end else begin
      // A held submission is dropped by any real key; count is already 0, so the
      // case below then behaves exactly as from EMPTY.
      if (state == ST_HELD && kc != KC_NONE) begin
        pin_n        = '0;
        state_n      = ST_EMPTY;
        key_accepted = 1'b1;
      end
      case (kc)
        KC_DIGIT: if (count != 3'd4) begin
          digits_n[count[1:0]] = key.tecla_value;
          count_n              = count + 3'd1;
          state_n              = ST_ENTRY;
          key_accepted         = 1'b1;
        end
        KC_BKSP: if (count != 3'd0) begin
          digits_n[bk_idx] = '0;
          count_n          = count - 3'd1;
          state_n          = (count == 3'd1) ? ST_EMPTY : ST_ENTRY;
          key_accepted     = 1'b1;
        end
        KC_CLEAR: begin
          count_n      = '0;
          digits_n     = '{default: '0};
          state_n      = ST_EMPTY;
          key_accepted = 1'b1;
        end
        KC_ENTER: if (count != 3'd0) begin
          if (count == 3'd4) begin
            pin_n   = '{status: 1'b1, digit1: digits[0], digit2: digits[1],
                        digit3: digits[2], digit4: digits[3]};
            valid_n = 1'b1;
            state_n = ST_HELD;
          end else begin
            error_n = 1'b1;
            state_n = ST_EMPTY;
          end
          count_n      = '0;
          digits_n     = '{default: '0};
          key_accepted = 1'b1;
        end
        default: ;
      endcase

      if (!key_accepted && expire) begin
        if (state == ST_ENTRY) begin
          timeout_n = 1'b1;
          count_n   = '0;
          digits_n  = '{default: '0};
        end else begin
          pin_n = '0;
        end
        state_n = ST_EMPTY;
      end
    end
  end

  // Display image is derived from the next state so it lands with the state change.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pos[i] = BCD_BLANK;
      if (state_n == ST_HELD) begin
        pos[i] = BCD_DASH;
      end else if (3'(i) < count_n) begin
`ifdef PIN_MASK_EN
        pos[i] = (3'(i) == count_n - 3'd1) ? digits_n[i] : BCD_DASH;
`else
        pos[i] = digits_n[i];
`endif
      end
    end
    disp_n = '{bcd5: BCD_BLANK, bcd4: BCD_BLANK, bcd3: pos[0],
               bcd2: pos[1], bcd1: pos[2], bcd0: pos[3]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_EMPTY;
      count       <= '0;
      digits      <= '{default: '0};
      pin_out     <= '0;
      pin_valid   <= 1'b0;
      pin_error   <= 1'b0;
      pin_timeout <= 1'b0;
      bcd_packet  <= {6{BCD_BLANK}};
      bcd_enable  <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      digits      <= digits_n;
      pin_out     <= pin_n;
      pin_valid   <= valid_n;
      pin_error   <= error_n;
      pin_timeout <= timeout_n;
      bcd_packet  <= disp_n;
      bcd_enable  <= (disp_n != bcd_packet);
    end
  end

endmodule

// File: tb/tb_pin_entry_buffer.sv
// Directed bench for pin_entry_buffer (TIMEOUT_TICKS=8); honours PIN_MASK_EN for display checks.
module tb_pin_entry_buffer;
  import pin_entry_buffer_pkg::*;

`ifdef PIN_MASK_EN
  localparam bit MASK = 1'b1;
`else
  localparam bit MASK = 1'b0;
`endif

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  logic    enable = 1'b1;
  pinPac_t pin_out;
  logic    pin_valid, pin_error, pin_timeout;
  bcdPac_t bcd_packet;
  logic    bcd_enable;
  state_t  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pin;

  pin_entry_buffer_if kif ();

  pin_entry_buffer #(.TIMEOUT_TICKS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .key         (kif.slave),
    .pin_out     (pin_out),
    .pin_valid   (pin_valid),
    .pin_error   (pin_error),
    .pin_timeout (pin_timeout),
    .bcd_packet  (bcd_packet),
    .bcd_enable  (bcd_enable),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; key is sampled at the next posedge, returns at the
  // following negedge with the registered result visible.
  task automatic press(input logic [3:0] k);
    kif.tecla_value = k;
    kif.tecla_valid = 1'b1;
    @(negedge clk);
    kif.tecla_valid = 1'b0;
    kif.tecla_value = 4'hA;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pulses"}, {29'd0, pin_valid, pin_error, pin_timeout}, 32'd0);
  endtask

  initial begin
    kif.tecla_value = 4'hA;
    kif.tecla_valid = 1'b0;
    idle(3);
    check("rst_bcd", 32'(bcd_packet), 32'hFFFFFF);
    check("rst_pin", 32'(pin_out), 32'd0);
    check_quiet("rst");
    check("rst_bcd_en", 32'(bcd_enable), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_EMPTY));
    reset = 1'b0;
    idle(1);

    // full PIN submit
    press(4'h1);
    check("d1_bcd", 32'(bcd_packet), 32'hFF1FFF);
    check("d1_en", 32'(bcd_enable), 32'd1);
    press(4'h2); press(4'h3); press(4'h4);
    check("d1234_bcd", 32'(bcd_packet), MASK ? 32'hFFBBB4 : 32'hFF1234);
    exp_q.push_back(32'h11234);
    press(KEY_ENTER);
    exp_pin = exp_q.pop_front();
    check("sub_valid", 32'(pin_valid), 32'd1);
    check("sub_pin", 32'(pin_out), exp_pin);
    check("sub_bcd", 32'(bcd_packet), 32'hFFBBBB);
    check("sub_state", 32'(state_dbg), 32'(ST_HELD));
    idle(1);
    check("sub_valid_1cyc", 32'(pin_valid), 32'd0);
    press(4'h5);
    check("held_exit_pin", 32'(pin_out), 32'd0);
    check("held_exit_bcd", 32'(bcd_packet), 32'hFF5FFF);
    check("held_exit_state", 32'(state_dbg), 32'(ST_ENTRY));
    press(KEY_CLEAR);
    check("clr_bcd", 32'(bcd_packet), 32'hFFFFFF);
    check_quiet("clr");

    // short submit
    press(4'h7); press(4'h8); press(KEY_ENTER);
    check("short_err", 32'(pin_error), 32'd1);
    check("short_bcd", 32'(bcd_packet), 32'hFFFFFF);
    check("short_status", 32'(pin_out.status), 32'd0);
    idle(1);
    check("short_err_1cyc", 32'(pin_error), 32'd0);

    // backspace
    press(4'h1); press(4'h2); press(4'h3); press(KEY_BKSP);
    check("bk_bcd", 32'(bcd_packet), MASK ? 32'hFFB2FF : 32'hFF12FF);
    press(4'h9); press(4'h4);
    exp_q.push_back(32'h11294);
    press(KEY_ENTER);
    exp_pin = exp_q.pop_front();
    check("bk_pin", 32'(pin_out), exp_pin);
    press(KEY_BKSP);
    check("bk_held_pin", 32'(pin_out), 32'd0);
    check("bk_held_en", 32'(bcd_enable), 32'd1);
    press(KEY_BKSP);
    check("bk_empty_en", 32'(bcd_enable), 32'd0);
    check("bk_empty_bcd", 32'(bcd_packet), 32'hFFFFFF);

    // overflow and ignored keys
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    check("ovf_en", 32'(bcd_enable), 32'd0);
    check("ovf_bcd", 32'(bcd_packet), MASK ? 32'hFFBBB4 : 32'hFF1234);
    press(4'hA); press(4'hC); press(4'hD);
    check("ign_en", 32'(bcd_enable), 32'd0);
    check_quiet("ign");
    check("ign_state", 32'(state_dbg), 32'(ST_ENTRY));
    press(KEY_CLEAR);

    // timeout in ENTRY
    press(4'h3);
    idle(7);
    check("to_early", 32'(pin_timeout), 32'd0);
    idle(1);
    check("to_pulse", 32'(pin_timeout), 32'd1);
    check("to_bcd", 32'(bcd_packet), 32'hFFFFFF);
    check("to_en", 32'(bcd_enable), 32'd1);
    idle(1);
    check("to_1cyc", 32'(pin_timeout), 32'd0);

    // key in the expiry cycle wins
    press(4'h3);
    idle(7);
    press(4'h4);
    check("to_race", 32'(pin_timeout), 32'd0);
    check("to_race_bcd", 32'(bcd_packet), MASK ? 32'hFFB4FF : 32'hFF34FF);
    press(KEY_CLEAR);

    // timeout in HELD is silent
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(KEY_ENTER);
    idle(7);
    check("hto_still", 32'(pin_out), 32'h11234);
    idle(1);
    check("hto_pin", 32'(pin_out), 32'd0);
    check("hto_silent", 32'(pin_timeout), 32'd0);
    check("hto_bcd", 32'(bcd_packet), 32'hFFFFFF);

    // enable drop mid-entry
    press(4'h1); press(4'h2); press(4'h3);
    check("en_bcd", 32'(bcd_packet), MASK ? 32'hFFBB3F : 32'hFF123F);
    enable = 1'b0;
    idle(1);
    check("dis_bcd", 32'(bcd_packet), 32'hFFFFFF);
    check("dis_en", 32'(bcd_enable), 32'd1);
    check("dis_state", 32'(state_dbg), 32'(ST_EMPTY));
    press(4'h5);
    check("dis_key_en", 32'(bcd_enable), 32'd0);
    check("dis_key_bcd", 32'(bcd_packet), 32'hFFFFFF);
    enable = 1'b1;
    idle(1);

    // async reset mid-entry
    press(4'h6); press(4'h7);
    #2 reset = 1'b1;
    #1;
    check("arst_bcd", 32'(bcd_packet), 32'hFFFFFF);
    check_quiet("arst");
    @(negedge clk);
    reset = 1'b0;
    idle(1);
    press(4'h8);
    check("arst_after", 32'(bcd_packet), 32'hFF8FFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
